mac_accumulator: RTL and testbench

//   Signed multiply-accumulate stage that sits directly downstream of the operand

---
 rtl/mac_accumulator_if.sv | 25 ++
 rtl/mac_accumulator.sv | 141 ++++++++++++++
 tb/tb_mac_accumulator.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
// Operand/result handshake bundle for mac_accumulator.
// The master side feeds operand pairs and consumes results. The slave side is the accumulator.
interface mac_accumulator_if #(
    parameter int SIZE     = 32,
    parameter int ACC_SIZE = 2*SIZE+8
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [SIZE-1:0]     a_in;
    logic signed [SIZE-1:0]     b_in;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [ACC_SIZE-1:0] result;
    logic                       out_sat;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, result, out_sat
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, result, out_sat
    );
endinterface

// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate: sums K_LEN products per result and holds the result behind valid/ready.
// Optional saturating accumulation is enabled by defining MAC_ACCUMULATOR_SATURATE_EN.
module mac_accumulator #(
    parameter int SIZE     = 32,
    parameter int ACC_SIZE = 2*SIZE+8,
    parameter int K_LEN    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    mac_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(K_LEN+1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_LEN-1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

    state_e                     state_q, state_d;
    logic signed [ACC_SIZE-1:0] acc_q, acc_d;
    logic signed [ACC_SIZE-1:0] result_q, result_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       out_valid_q, out_valid_d;

    logic                       in_ready;
    logic                       accept;
    logic                       pop;
    logic                       first_term;
    logic                       last_term;
    logic [CNT_W-1:0]           cnt_base;
    logic signed [2*SIZE-1:0]   prod;
    logic signed [ACC_SIZE-1:0] prod_ext;
    logic signed [ACC_SIZE-1:0] base;
    logic signed [ACC_SIZE-1:0] sum;

    assign in_ready = enable & ((state_q != HOLD) | bus.out_ready);
    assign accept   = enable & bus.in_valid & in_ready;
    assign pop      = enable & out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    // Outside ACCUM the incoming pair always starts a fresh sum, so the running
    // acc/cnt are ignored rather than relying on them having been cleared.
    assign first_term = (state_q != ACCUM);
    assign base       = first_term ? '0 : acc_q;
    assign cnt_base   = first_term ? '0 : cnt_q;
    assign last_term  = (cnt_base == LAST_CNT);

    assign prod     = bus.a_in * bus.b_in;
    assign prod_ext = ACC_SIZE'(prod);

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

    logic [ACC_SIZE:0] sum_wide;
    logic              step_ovf;
    logic              sat_term;
    logic              sat_run_q, sat_run_d;
    logic              out_sat_q, out_sat_d;

    // One extra bit exposes signed overflow; the top bit then picks the clamp direction.
    assign sum_wide = {base[ACC_SIZE-1], base} + {prod_ext[ACC_SIZE-1], prod_ext};
    assign step_ovf = sum_wide[ACC_SIZE] ^ sum_wide[ACC_SIZE-1];
    assign sum      = step_ovf ? (sum_wide[ACC_SIZE] ? ACC_MIN : ACC_MAX)
                               : sum_wide[ACC_SIZE-1:0];
    assign sat_term = (first_term ? 1'b0 : sat_run_q) | step_ovf;

    always_comb begin
        sat_run_d = sat_run_q;
        out_sat_d = out_sat_q;
        if (accept) begin
            if (last_term) begin
                sat_run_d = 1'b0;
                out_sat_d = sat_term;
            end else begin
                sat_run_d = sat_term;
                if (first_term) out_sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_run_q <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_run_q <= sat_run_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign bus.out_sat = out_sat_q;
`else
    assign sum         = base + prod_ext;
    assign bus.out_sat = 1'b0;
`endif

    // A pop releases HOLD; an accept in the same cycle then overrides with the next term.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
        if (accept) begin
            if (last_term) begin
                result_d    = sum;
                out_valid_d = 1'b1;
                state_d     = HOLD;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d   = sum;
                cnt_d   = cnt_base + 1'b1;
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a wide instance for dot products and an 8/16-bit one for overflow.
module tb_mac_accumulator;
    logic clk = 1'b0;
    logic reset_n;
    logic enable;

    always #5 clk = ~clk;

    mac_accumulator_if #(.SIZE(32), .ACC_SIZE(72)) m_if ();
    mac_accumulator_if #(.SIZE(8),  .ACC_SIZE(16)) s_if ();

    mac_accumulator #(.SIZE(32), .ACC_SIZE(72), .K_LEN(8)) dut_m (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bus(m_if.slave)
    );
    mac_accumulator #(.SIZE(8), .ACC_SIZE(16), .K_LEN(8)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .bus(s_if.slave)
    );

    typedef struct packed {
        logic signed [71:0] res;
        logic               sat;
    } exp_t;

    exp_t q_m[$];
    exp_t q_s[$];
    int   checks   = 0;
    int   failures = 0;
    logic both_seen;

    task automatic chk(input string name, input logic signed [71:0] act, input logic signed [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_m(input logic signed [71:0] r, input logic s);
        exp_t e;
        e.res = r;
        e.sat = s;
        q_m.push_back(e);
    endtask

    task automatic push_s(input logic signed [71:0] r, input logic s);
        exp_t e;
        e.res = r;
        e.sat = s;
        q_s.push_back(e);
    endtask

    // Monitors: compare every popped result against the head of its queue.
    always @(negedge clk) begin
        if (reset_n && enable && m_if.out_valid && m_if.out_ready) begin
            if (q_m.size() == 0) begin
                chk("m_unexpected_result", m_if.result, 72'sd0);
                chk("m_unexpected_pop", 1, 0);
            end else begin
                exp_t e;
                e = q_m.pop_front();
                chk("m_result", m_if.result, e.res);
                chk("m_out_sat", {71'd0, m_if.out_sat}, {71'd0, e.sat});
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && enable && s_if.out_valid && s_if.out_ready) begin
            if (q_s.size() == 0) begin
                chk("s_unexpected_pop", 1, 0);
            end else begin
                exp_t e;
                e = q_s.pop_front();
                chk("s_result", s_if.result, e.res);
                chk("s_out_sat", {71'd0, s_if.out_sat}, {71'd0, e.sat});
            end
        end
    end

    // Present one pair and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic beat(input logic signed [31:0] a, input logic signed [31:0] b);
        int n;
        m_if.in_valid = 1'b1;
        m_if.a_in     = a;
        m_if.b_in     = b;
        n = 0;
        @(negedge clk);
        while (!(m_if.in_ready && enable) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("m_accept_timeout", n, 0);
        both_seen = m_if.in_ready && m_if.out_valid && m_if.out_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic sbeat(input logic signed [7:0] a, input logic signed [7:0] b);
        int n;
        s_if.in_valid = 1'b1;
        s_if.a_in     = a;
        s_if.b_in     = b;
        n = 0;
        @(negedge clk);
        while (!s_if.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("s_accept_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_m();
        m_if.in_valid = 1'b0;
        m_if.a_in     = '0;
        m_if.b_in     = '0;
    endtask

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b1;
        both_seen      = 1'b0;
        m_if.in_valid  = 1'b0;
        m_if.a_in      = '0;
        m_if.b_in      = '0;
        m_if.out_ready = 1'b1;
        s_if.in_valid  = 1'b0;
        s_if.a_in      = '0;
        s_if.b_in      = '0;
        s_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {71'd0, m_if.out_valid}, 72'sd0);
        chk("reset_result", m_if.result, 72'sd0);
        chk("reset_out_sat", {71'd0, m_if.out_sat}, 72'sd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", {71'd0, m_if.in_ready}, 72'sd1);

        // Basic sum: sum(i*2, i=1..8) = 72
        push_m(72, 1'b0);
        for (int i = 1; i <= 8; i++) beat(i, 2);
        idle_m();
        chk("latency_out_valid", {71'd0, m_if.out_valid}, 72'sd1);
        repeat (2) @(posedge clk);
        #1;

        // Signed: 8 * (-3*5) = -120
        push_m(-120, 1'b0);
        for (int i = 0; i < 8; i++) beat(-3, 5);
        idle_m();
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: 3*(1..8) = 108 held for 5 cycles
        m_if.out_ready = 1'b0;
        push_m(108, 1'b0);
        for (int i = 1; i <= 8; i++) beat(i, 3);
        idle_m();
        m_if.in_valid = 1'b1;
        m_if.a_in     = 32'sd99;
        m_if.b_in     = 32'sd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_result_stable", m_if.result, 72'sd108);
            chk("bp_in_ready_low", {71'd0, m_if.in_ready}, 72'sd0);
            chk("bp_out_valid_high", {71'd0, m_if.out_valid}, 72'sd1);
        end
        @(posedge clk);
        #1;
        // Pop and first accept coincide; next sum = -(10+..+17) = -108
        m_if.out_ready = 1'b1;
        push_m(-108, 1'b0);
        for (int k = 10; k <= 17; k++) begin
            beat(k, -1);
            if (k == 10) chk("bp_pop_and_accept", {71'd0, both_seen}, 72'sd1);
        end
        idle_m();
        repeat (2) @(posedge clk);
        #1;

        // Stall: enable low for 4 cycles after the 3rd beat, same sum as basic
        push_m(72, 1'b0);
        for (int i = 1; i <= 3; i++) beat(i, 2);
        enable        = 1'b0;
        m_if.in_valid = 1'b1;
        m_if.a_in     = 32'sd4;
        m_if.b_in     = 32'sd2;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_in_ready_low", {71'd0, m_if.in_ready}, 72'sd0);
            chk("stall_out_valid_low", {71'd0, m_if.out_valid}, 72'sd0);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        for (int i = 4; i <= 8; i++) beat(i, 2);
        idle_m();
        repeat (2) @(posedge clk);
        #1;
        chk("stall_result_kept", m_if.result, 72'sd72);

        // Reset mid-run discards a partial sum of 3
        for (int i = 0; i < 3; i++) beat(1, 1);
        idle_m();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {71'd0, m_if.out_valid}, 72'sd0);
        chk("midrst_result", m_if.result, 72'sd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_m(8, 1'b0);
        for (int i = 0; i < 8; i++) beat(1, 1);
        idle_m();
        repeat (2) @(posedge clk);
        #1;

        // Overflow on the 8/16-bit instance: 8 * 16384 = 131072
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        push_s(32767, 1'b1);
`else
        push_s(0, 1'b0);
`endif
        for (int i = 0; i < 8; i++) sbeat(-8'sd128, -8'sd128);
        s_if.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("m_queue_drained", q_m.size(), 0);
        chk("s_queue_drained", q_s.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
